// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle-handshake clock-domain crossing.
package cdc_pkg;

    // Source-side handshake state: IDLE accepts a word, BUSY waits for the ack toggle.
    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_BUSY = 1'b1
    } hs_state_t;

    // Shallowest synchronizer chain considered safe for metastability settling.
    localparam int CDC_MIN_STAGE = 2;

endpackage

// File: rtl/cdc_toggle_sync.sv
// Single-bit level/toggle synchronizer: N_STAGE flops into the destination clock.
// Depth is clamped to the safe minimum so a mis-set parameter cannot produce a 1-flop chain.
module cdc_toggle_sync
    import cdc_pkg::*;
#(
    parameter int N_STAGE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int DEPTH = (N_STAGE < CDC_MIN_STAGE) ? CDC_MIN_STAGE : N_STAGE;

    (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] sync_q;

    // Shift the asynchronous input through the chain; the last flop is the settled output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[DEPTH-2:0], d};
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_handshake_bus.sv
// Multi-bit clock-domain crossing with a toggle req/ack handshake.
// The source captures one word into hold_q and keeps it frozen until the destination's ack
// toggle returns, so the destination may sample hold_q directly once the req toggle arrives.
// Optional feature: define CDC_HS_XFER_CNT_EN to add the xfer_cnt completed-transfer counter.
module cdc_handshake_bus
    import cdc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_STAGE = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              clk_out,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
`ifdef CDC_HS_XFER_CNT_EN
    ,
    output logic [31:0]       xfer_cnt
`endif
);

    hs_state_t         state;
    logic [DATA_W-1:0] hold_q;
    logic              req_tgl;
    logic              ack_tgl;
    logic              req_sync;
    logic              ack_sync;
    logic              req_seen;
    logic              ack_done;

    // The ack has come back once the synchronized ack toggle matches our req toggle.
    assign ack_done = (state == HS_BUSY) && (ack_sync == req_tgl);

    // Source FSM: capture a word, flip req, then wait for the matching ack before re-opening.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= HS_IDLE;
            s_ready <= 1'b1;
            hold_q  <= '0;
            req_tgl <= 1'b0;
        end else begin
            case (state)
                HS_IDLE: begin
                    if (s_valid && s_ready) begin
                        hold_q  <= s_data;
                        req_tgl <= ~req_tgl;
                        state   <= HS_BUSY;
                        s_ready <= 1'b0;
                    end
                end
                HS_BUSY: begin
                    if (ack_done) begin
                        state   <= HS_IDLE;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= HS_IDLE;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CDC_HS_XFER_CNT_EN
    logic [31:0] cnt_q;

    // Count each completed round trip; wraps naturally at 2^32.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)           cnt_q <= '0;
        else if (ack_done) cnt_q <= cnt_q + 32'd1;
    end

    assign xfer_cnt = cnt_q;
`endif

    cdc_toggle_sync #(.N_STAGE(N_STAGE)) u_req_sync (
        .clk (clk_out),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_sync)
    );

    cdc_toggle_sync #(.N_STAGE(N_STAGE)) u_ack_sync (
        .clk (clk_in),
        .rst (rst),
        .d   (ack_tgl),
        .q   (ack_sync)
    );

    // Destination: load the held word on a req edge, return ack only after it is consumed.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            m_data   <= '0;
            m_valid  <= 1'b0;
            req_seen <= 1'b0;
            ack_tgl  <= 1'b0;
        end else if (!m_valid && (req_sync != req_seen)) begin
            m_data   <= hold_q;
            m_valid  <= 1'b1;
            req_seen <= req_sync;
        end else if (m_valid && m_ready) begin
            m_valid  <= 1'b0;
            ack_tgl  <= req_seen;
        end
    end

endmodule
